cdc_fifo_bridge: RTL and testbench
==================================

Name: cdc_fifo_bridge

Overview:
- Parametrised successor to the fixed CPU-side FIFO interface between the RV32 core's memory-mapped bus and the USB_CDC byte streams.
- Holds two independent byte FIFOs with separately sized depths:
  - IN FIFO: CPU→host.
  - OUT FIFO: host→CPU.
- Adds a programmable control register, interrupt thresholds, occupancy counters and sticky overflow/underflow flags.
- Sits on the core's data bus beside mem_control and drives the USB_CDC IN/OUT handshake ports directly.

Parameters:
- IN_DEPTH, 16, IN FIFO entries; power of 2, range 2..128.
- OUT_DEPTH, 16, OUT FIFO entries; power of 2, range 2..128.
- OUT_THRESH_RST, 1, reset value of the out_thresh field; must be ≤ OUT_DEPTH.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- sel_i  in  1  bus select.
- read_i  in  1  register read strobe, qualified by sel_i.
- write_i  in  1  register write strobe, qualified by sel_i.
- addr_i  in  2  word register index.
- data_i  in  32  write data.
- data_o  out  32  registered read data.
- in_irq_o  out  1  IN space interrupt, level.
- out_irq_o  out  1  OUT data interrupt, level.
- in_data_o  out  8  byte to host.
- in_valid_o  out  1  in_data_o valid.
- in_ready_i  in  1  host accepts byte.
- out_data_i  in  8  byte from host.
- out_valid_i  in  1  out_data_i valid; held until consumed.
- out_ready_o  out  1  bridge accepts byte.

Behaviour:
- Reset: all state clears on the clk_i edge while rst_i=1.
  - Both FIFOs empty, counts 0.
  - data_o=0, in_irq_o=0, out_irq_o=0, in_valid_o=0.
  - out_ready_o=0 while rst_i=1.
  - CTRL = {out_thresh=OUT_THRESH_RST, in_thresh=0, enables=0}; sticky flags 0.
  - Reset mid-transfer discards FIFO contents with no partial handshake completion.
- Bus access: an access occurs only when sel_i=1.
  - Read: data_o is updated one cycle after read_i; data_o holds its value when no read occurs.
  - Write: takes effect at the edge where write_i is sampled.
  - read_i and write_i both high: both actions are performed; the read returns pre-write register state.
- Register map:
  - addr 0, DATA:
    - Write pushes data_i[7:0] into the IN FIFO.
    - Read pops the OUT FIFO and returns {23'b0, 1'b1, byte}.
    - Read when OUT is empty returns 0, pops nothing and sets out_udf.
  - addr 1, STATUS (read):
    - [7:0] in_count, [15:8] out_count.
    - [16] in_full, [17] in_empty, [18] out_full, [19] out_empty.
    - [20] in_ovf, [21] out_udf.
    - Writing 1 to bits 20/21 clears the matching flag; other bits are read-only.
  - addr 2, CTRL (R/W):
    - [0] in_irq_en, [1] out_irq_en, [15:8] in_thresh, [23:16] out_thresh.
    - Unused bits read 0.
  - addr 3: reads 0; writes ignored.
- IN FIFO (CPU→host):
  - First-word-fall-through: in_valid_o = !in_empty; in_data_o = head entry.
  - Host pop when in_valid_o && in_ready_i.
  - CPU push accepted if !in_full, or if a host pop occurs in the same cycle.
  - Push to a full FIFO with no same-cycle pop is dropped and sets in_ovf (sticky).
  - Flag set and a W1C clear in the same cycle: set wins.
- OUT FIFO (host→CPU):
  - out_ready_o = !out_full && !rst_i; host push when out_valid_i && out_ready_o.
  - Simultaneous host push and CPU pop while empty: no bypass; the read returns empty, the byte is stored, out_udf sets.
  - Simultaneous push and pop while non-empty: count unchanged.
- Pointers: log2(DEPTH)-bit read/write pointers that wrap naturally; separate count register (0..DEPTH) derives full and empty.
- Interrupts: registered, so they assert one cycle after the condition becomes true.
  - in_irq_o = in_irq_en && (in_count ≤ in_thresh).
  - out_irq_o = out_irq_en && (out_thresh≠0) && (out_count ≥ out_thresh).
  - Threshold compares are unsigned 8-bit; counts are zero-extended.

Test Plan:
- Reset, then read STATUS → data_o=0x000A0000 (in_empty, out_empty) one cycle after read; out_ready_o=1 the cycle after rst_i falls.
- in_ready_i=0, write DATA 0x41,0x42 → in_valid_o=1, in_data_o=0x41. Raise in_ready_i for 2 cycles → bytes 0x41 then 0x42 emitted, then in_valid_o=0.
- Host pushes 0x55 → read DATA returns 0x00000155; next DATA read returns 0, STATUS bit21=1. Write STATUS 0x00200000 → bit21 clears.
- Fill IN to 16 with in_ready_i=0, write a 17th byte → dropped, in_count=16, in_ovf=1. Repeat the 17th write with in_ready_i=1 in the same cycle → accepted, in_count stays 16.
- Host streams bytes with no CPU reads → out_ready_o=0 after the 16th; out_valid_i held; after one DATA read, out_ready_o=1 and the held byte is accepted.
- CTRL=0x00030003 (out_thresh 3, both enables set): out_irq_o=1 the cycle after the third OUT byte. in_irq_o=1 while in_count≤0; pushing one IN byte with in_ready_i=0 deasserts it one cycle later.

Source files
------------

// File: rtl/cdc_fifo_bridge.sv
// CPU-side bridge between the core data bus and the USB CDC byte streams.
// Two byte FIFOs (IN: CPU->host, OUT: host->CPU), a control register with
// interrupt thresholds, occupancy counters and sticky overflow/underflow flags.
module cdc_fifo_bridge #(
    parameter int unsigned IN_DEPTH       = 16,
    parameter int unsigned OUT_DEPTH      = 16,
    parameter int unsigned OUT_THRESH_RST = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        in_irq_o,
    output logic        out_irq_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    input  logic [7:0]  out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o
);

    localparam int unsigned IN_AW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int unsigned IN_CW  = IN_AW + 1;
    localparam int unsigned OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned OUT_CW = OUT_AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        in_mem_q  [IN_DEPTH];
    logic [7:0]        out_mem_q [OUT_DEPTH];

    logic [IN_AW-1:0]  in_wr_ptr_q,  in_wr_ptr_d;
    logic [IN_AW-1:0]  in_rd_ptr_q,  in_rd_ptr_d;
    logic [IN_CW-1:0]  in_count_q,   in_count_d;
    logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [OUT_AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [OUT_CW-1:0] out_count_q,  out_count_d;

    logic              in_irq_en_q,  in_irq_en_d;
    logic              out_irq_en_q, out_irq_en_d;
    logic [7:0]        in_thresh_q,  in_thresh_d;
    logic [7:0]        out_thresh_q, out_thresh_d;
    logic              in_ovf_q,     in_ovf_d;
    logic              out_udf_q,    out_udf_d;
    logic [31:0]       data_q,       data_d;
    logic              in_irq_q,     in_irq_d;
    logic              out_irq_q,    out_irq_d;

    // ------------------------------------------------------------------
    // Decode / handshake signals
    // ------------------------------------------------------------------
    logic        bus_rd, bus_wr;
    logic        in_full, in_empty, out_full, out_empty;
    logic        in_pop, in_push_req, in_push, in_ovf_set;
    logic        out_push, out_pop_req, out_pop, out_udf_set;
    logic        status_wr, ctrl_wr;
    logic [7:0]  in_count8, out_count8;
    logic [31:0] status_word, ctrl_word, rd_data;
    logic        unused_bits;

    assign unused_bits = ^data_i[31:24];

    // Bus strobes, FIFO flags and per-cycle push/pop decisions
    always_comb begin
        bus_rd      = sel_i && read_i;
        bus_wr      = sel_i && write_i;

        in_full     = (in_count_q == IN_CW'(IN_DEPTH));
        in_empty    = (in_count_q == '0);
        out_full    = (out_count_q == OUT_CW'(OUT_DEPTH));
        out_empty   = (out_count_q == '0);

        in_count8   = 8'(in_count_q);
        out_count8  = 8'(out_count_q);

        // A host pop frees a slot in the same cycle, so a push to a full
        // FIFO is still accepted when it coincides with a pop.
        in_pop      = !in_empty && in_ready_i;
        in_push_req = bus_wr && (addr_i == ADDR_DATA);
        in_push     = in_push_req && (!in_full || in_pop);
        in_ovf_set  = in_push_req && in_full && !in_pop;

        // No bypass: a CPU read of an empty OUT FIFO underflows even if the
        // host is pushing in the same cycle.
        out_push    = out_valid_i && !out_full && !rst_i;
        out_pop_req = bus_rd && (addr_i == ADDR_DATA);
        out_pop     = out_pop_req && !out_empty;
        out_udf_set = out_pop_req && out_empty;

        status_wr   = bus_wr && (addr_i == ADDR_STATUS);
        ctrl_wr     = bus_wr && (addr_i == ADDR_CTRL);
    end

    // Pointer and occupancy next-state for both FIFOs
    always_comb begin
        in_wr_ptr_d  = in_wr_ptr_q;
        in_rd_ptr_d  = in_rd_ptr_q;
        in_count_d   = in_count_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_count_d  = out_count_q;

        if (in_push) begin
            in_wr_ptr_d = in_wr_ptr_q + IN_AW'(1);
        end
        if (in_pop) begin
            in_rd_ptr_d = in_rd_ptr_q + IN_AW'(1);
        end
        case ({in_push, in_pop})
            2'b10:   in_count_d = in_count_q + IN_CW'(1);
            2'b01:   in_count_d = in_count_q - IN_CW'(1);
            default: in_count_d = in_count_q;
        endcase

        if (out_push) begin
            out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(1);
        end
        if (out_pop) begin
            out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
        end
        case ({out_push, out_pop})
            2'b10:   out_count_d = out_count_q + OUT_CW'(1);
            2'b01:   out_count_d = out_count_q - OUT_CW'(1);
            default: out_count_d = out_count_q;
        endcase
    end

    // Control register, sticky flags (set beats W1C) and interrupt levels
    always_comb begin
        in_irq_en_d  = in_irq_en_q;
        out_irq_en_d = out_irq_en_q;
        in_thresh_d  = in_thresh_q;
        out_thresh_d = out_thresh_q;
        in_ovf_d     = in_ovf_q;
        out_udf_d    = out_udf_q;

        if (ctrl_wr) begin
            in_irq_en_d  = data_i[0];
            out_irq_en_d = data_i[1];
            in_thresh_d  = data_i[15:8];
            out_thresh_d = data_i[23:16];
        end

        if (status_wr && data_i[20]) begin
            in_ovf_d = 1'b0;
        end
        if (status_wr && data_i[21]) begin
            out_udf_d = 1'b0;
        end
        if (in_ovf_set) begin
            in_ovf_d = 1'b1;
        end
        if (out_udf_set) begin
            out_udf_d = 1'b1;
        end

        // Evaluated on current state, so the level follows one cycle later
        in_irq_d  = in_irq_en_q && (in_count8 <= in_thresh_q);
        out_irq_d = out_irq_en_q && (out_thresh_q != 8'd0)
                    && (out_count8 >= out_thresh_q);
    end

    // Read mux over pre-write state; data_o only moves on a read
    always_comb begin
        status_word = {10'd0, out_udf_q, in_ovf_q,
                       out_empty, out_full, in_empty, in_full,
                       out_count8, in_count8};
        ctrl_word   = {8'd0, out_thresh_q, in_thresh_q, 6'd0,
                       out_irq_en_q, in_irq_en_q};
        rd_data     = 32'd0;

        case (addr_i)
            ADDR_DATA: begin
                if (!out_empty) begin
                    rd_data = {23'd0, 1'b1, out_mem_q[out_rd_ptr_q]};
                end
            end
            ADDR_STATUS: rd_data = status_word;
            ADDR_CTRL:   rd_data = ctrl_word;
            default:     rd_data = 32'd0;
        endcase

        data_d = bus_rd ? rd_data : data_q;
    end

    // Register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_count_q   <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
            in_irq_en_q  <= 1'b0;
            out_irq_en_q <= 1'b0;
            in_thresh_q  <= 8'd0;
            out_thresh_q <= 8'(OUT_THRESH_RST);
            in_ovf_q     <= 1'b0;
            out_udf_q    <= 1'b0;
            data_q       <= 32'd0;
            in_irq_q     <= 1'b0;
            out_irq_q    <= 1'b0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_count_q   <= in_count_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_count_q  <= out_count_d;
            in_irq_en_q  <= in_irq_en_d;
            out_irq_en_q <= out_irq_en_d;
            in_thresh_q  <= in_thresh_d;
            out_thresh_q <= out_thresh_d;
            in_ovf_q     <= in_ovf_d;
            out_udf_q    <= out_udf_d;
            data_q       <= data_d;
            in_irq_q     <= in_irq_d;
            out_irq_q    <= out_irq_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers own validity
    always_ff @(posedge clk_i) begin
        if (in_push && !rst_i) begin
            in_mem_q[in_wr_ptr_q] <= data_i[7:0];
        end
        if (out_push) begin
            out_mem_q[out_wr_ptr_q] <= out_data_i;
        end
    end

    // Output drive
    assign data_o      = data_q;
    assign in_irq_o    = in_irq_q;
    assign out_irq_o   = out_irq_q;
    assign in_data_o   = in_mem_q[in_rd_ptr_q];
    assign in_valid_o  = !in_empty;
    assign out_ready_o = !out_full && !rst_i;

endmodule

// File: tb/tb_cdc_fifo_bridge.sv
// Directed bench for cdc_fifo_bridge: register map, both FIFOs, flags, irqs.
module tb_cdc_fifo_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sel_i, read_i, write_i;
    logic [1:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        in_irq_o, out_irq_o;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i;
    logic [7:0]  out_data_i;
    logic        out_valid_i;
    logic        out_ready_o;

    int passed = 0;
    int total  = 0;

    cdc_fifo_bridge dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sel_i      (sel_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .in_irq_o   (in_irq_o),
        .out_irq_o  (out_irq_o),
        .in_data_o  (in_data_o),
        .in_valid_o (in_valid_o),
        .in_ready_i (in_ready_i),
        .out_data_i (out_data_i),
        .out_valid_i(out_valid_i),
        .out_ready_o(out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel_i = 1'b1; write_i = 1'b1; addr_i = a; data_i = d;
        tick();
        sel_i = 1'b0; write_i = 1'b0; data_i = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        sel_i = 1'b1; read_i = 1'b1; addr_i = a;
        tick();
        sel_i = 1'b0; read_i = 1'b0;
        chk(tag, data_o, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        addr_i = 2'd0; data_i = 32'd0; in_ready_i = 1'b0;
        out_data_i = 8'd0; out_valid_i = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_in_valid", 32'(in_valid_o), 32'd0);
        chk("rst_out_ready", 32'(out_ready_o), 32'd0);
        chk("rst_irqs", {30'd0, in_irq_o, out_irq_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("out_ready_after_rst", 32'(out_ready_o), 32'd1);
        bus_read(2'd1, 32'h000A_0000, "status_after_rst");

        // IN FIFO first-word-fall-through and host drain
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        chk("in_valid_2", 32'(in_valid_o), 32'd1);
        chk("in_head_41", 32'(in_data_o), 32'h41);
        bus_read(2'd1, 32'h0008_0002, "status_in2");
        in_ready_i = 1'b1;
        chk("emit_41", 32'(in_data_o), 32'h41);
        tick();
        chk("emit_42", 32'(in_data_o), 32'h42);
        chk("valid_42", 32'(in_valid_o), 32'd1);
        tick();
        in_ready_i = 1'b0;
        chk("in_drained", 32'(in_valid_o), 32'd0);

        // OUT FIFO read, underflow and W1C
        out_valid_i = 1'b1; out_data_i = 8'h55;
        tick();
        out_valid_i = 1'b0;
        bus_read(2'd0, 32'h0000_0155, "out_read_55");
        bus_read(2'd0, 32'h0000_0000, "out_read_empty");
        bus_read(2'd1, 32'h002A_0000, "status_udf");
        bus_write(2'd1, 32'h0020_0000);
        bus_read(2'd1, 32'h000A_0000, "status_udf_clr");

        // IN overflow and full-with-pop acceptance
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h10 + 32'(i));
        bus_read(2'd1, 32'h0009_0010, "status_in_full");
        bus_write(2'd0, 32'hEE);
        bus_read(2'd1, 32'h0019_0010, "status_in_ovf");
        in_ready_i = 1'b1;
        bus_write(2'd0, 32'hEF);
        in_ready_i = 1'b0;
        chk("in_head_after_swap", 32'(in_data_o), 32'h11);
        bus_read(2'd1, 32'h0019_0010, "status_full_pop");
        bus_write(2'd1, 32'h0010_0000);
        bus_read(2'd1, 32'h0009_0010, "status_ovf_clr");
        in_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("in_drain_%0d", i), 32'(in_data_o),
                (i < 15) ? 32'h11 + 32'(i) : 32'hEF);
            tick();
        end
        in_ready_i = 1'b0;
        chk("in_empty_after_drain", 32'(in_valid_o), 32'd0);

        // OUT FIFO backpressure
        out_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            out_data_i = 8'h60 + 8'(i);
            tick();
        end
        out_data_i = 8'h70;
        chk("out_ready_full", 32'(out_ready_o), 32'd0);
        tick();
        chk("out_ready_full_held", 32'(out_ready_o), 32'd0);
        bus_read(2'd0, 32'h0000_0160, "out_read_60");
        chk("out_ready_reopen", 32'(out_ready_o), 32'd1);
        tick();
        out_valid_i = 1'b0;
        chk("out_ready_refull", 32'(out_ready_o), 32'd0);
        bus_read(2'd1, 32'h0006_1000, "status_out_full");
        for (int i = 0; i < 16; i++)
            bus_read(2'd0, (i < 15) ? 32'h161 + 32'(i) : 32'h170,
                     $sformatf("out_drain_%0d", i));
        bus_read(2'd1, 32'h000A_0000, "status_both_empty");

        // Interrupts
        bus_write(2'd2, 32'h0003_0003);
        tick();
        chk("in_irq_on", 32'(in_irq_o), 32'd1);
        chk("out_irq_off", 32'(out_irq_o), 32'd0);
        bus_read(2'd2, 32'h0003_0003, "ctrl_read");
        out_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_data_i = 8'hA0 + 8'(i);
            tick();
        end
        out_valid_i = 1'b0;
        tick();
        chk("out_irq_on", 32'(out_irq_o), 32'd1);
        bus_write(2'd0, 32'h99);
        tick();
        chk("in_irq_off", 32'(in_irq_o), 32'd0);
        bus_read(2'd0, 32'h0000_01A0, "out_read_a0");
        tick();
        chk("out_irq_below", 32'(out_irq_o), 32'd0);

        // Simultaneous read+write returns pre-write state; addr 3 reads 0
        sel_i = 1'b1; read_i = 1'b1; write_i = 1'b1; addr_i = 2'd2; data_i = 32'd0;
        tick();
        sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        chk("rw_prewrite", data_o, 32'h0003_0003);
        bus_read(2'd2, 32'h0000_0000, "ctrl_after_rw");
        bus_read(2'd1, 32'h0000_0201, "status_mixed");
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, 32'h0000_0000, "addr3_read");

        // Reset mid-transfer
        bus_read(2'd1, 32'h0000_0201, "status_pre_rst");
        in_ready_i = 1'b1; out_valid_i = 1'b1; out_data_i = 8'hBB; rst_i = 1'b1;
        tick();
        chk("mid_rst_in_valid", 32'(in_valid_o), 32'd0);
        chk("mid_rst_out_ready", 32'(out_ready_o), 32'd0);
        chk("mid_rst_data_o", data_o, 32'd0);
        rst_i = 1'b0; in_ready_i = 1'b0; out_valid_i = 1'b0;
        tick();
        bus_read(2'd1, 32'h000A_0000, "status_post_rst");
        bus_read(2'd2, 32'h0001_0000, "ctrl_post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
